// File: rtl/twiddle_mult_stream0_1_if.sv
// Stream bundle between a sample source and the twiddle multiplier.
// Input side carries valid/ready/sof plus a complex sample.
// Output side carries valid/ready, the rounded and saturated complex product, and
// sof/eof/sat flags.
// modport master: the environment (drives in_*, out_ready).
// modport slave:  the multiplier (drives in_ready, out_*).
interface twiddle_mult_stream0_1_if #(
  parameter int unsigned DBITS = 11
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sof;
  logic signed [DBITS-1:0] in_re;
  logic signed [DBITS-1:0] in_im;

  logic                    out_valid;
  logic                    out_ready;
  logic signed [DBITS-1:0] out_re;
  logic signed [DBITS-1:0] out_im;
  logic                    out_sof;
  logic                    out_eof;
  logic                    out_sat;

  modport master (
    output in_valid, in_sof, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_sof, out_eof, out_sat
  );

  modport slave (
    input  in_valid, in_sof, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_sof, out_eof, out_sat
  );
endinterface

// File: rtl/twiddle_mult_stream0_1.sv
// Streaming complex twiddle multiplier for FFT stage 0_1.
// Each accepted sample k of an N-sample frame is multiplied by coefficient k taken from the
// packed coefficient bus, rounded half up, saturated to DBITS and forwarded downstream.
// Three register stages with a global stall; latency 3 cycles when not stalled.
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   coeff_data_i packed coefficients, entry k = coeff_data_i[(N-k)*2*NBITS-1 -: 2*NBITS], {re,im}
//   bus_io       stream interface (slave side): in_* sample input, out_* product output
module twiddle_mult_stream0_1 #(
  parameter int unsigned NBITS = 11,
  parameter int unsigned N     = 32,
  parameter int unsigned DBITS = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2*NBITS*N-1:0]   coeff_data_i,
  twiddle_mult_stream0_1_if.slave bus_io
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW = DBITS + NBITS;  // partial product width
  localparam int unsigned SW = PW + 1;         // sum width
  localparam int unsigned SH = NBITS - 2;      // Q1.(NBITS-2) fraction bits

  localparam logic signed [SW-1:0] RndC = SW'(2 ** (NBITS - 3));
  localparam logic signed [SW-1:0] MaxC = SW'(2 ** (DBITS - 1) - 1);
  localparam logic signed [SW-1:0] MinC = SW'(-(2 ** (DBITS - 1)));

  // Coefficient table unpacked from the quasi-static bus.
  logic signed [NBITS-1:0] coef_re [N];
  logic signed [NBITS-1:0] coef_im [N];

  for (genvar k = 0; k < N; k++) begin : g_coef
    assign coef_re[k] = coeff_data_i[(N-k)*2*NBITS-1 -: NBITS];
    assign coef_im[k] = coeff_data_i[(N-k)*2*NBITS-1-NBITS -: NBITS];
  end

  // Global stall: everything holds while the output is blocked.
  logic stall;
  logic accept;
  logic out_valid_q;

  assign stall           = out_valid_q & ~bus_io.out_ready;
  assign bus_io.in_ready = ~stall;
  assign accept          = bus_io.in_valid & ~stall;

  // Frame index; in_sof forces index 0 and wins over the wrap.
  logic [IW-1:0] idx_q, idx_d, sel;

  always_comb begin
    sel   = bus_io.in_sof ? '0 : idx_q;
    idx_d = idx_q;
    if (accept) begin
      idx_d = (sel == IW'(N - 1)) ? '0 : sel + IW'(1);
    end
  end

  // Stage 1: sample, selected coefficient, frame flags.
  logic                    v1_q, sof1_q, eof1_q;
  logic signed [DBITS-1:0] a1_q, b1_q;
  logic signed [NBITS-1:0] c1_q, d1_q;

  // Stage 2: partial products.
  logic                    v2_q, sof2_q, eof2_q;
  logic signed [PW-1:0]    ac_q, bd_q, ad_q, bc_q;
  logic signed [PW-1:0]    ac_d, bd_d, ad_d, bc_d;

  always_comb begin
    ac_d = PW'(a1_q) * PW'(c1_q);
    bd_d = PW'(b1_q) * PW'(d1_q);
    ad_d = PW'(a1_q) * PW'(d1_q);
    bc_d = PW'(b1_q) * PW'(c1_q);
  end

  // Stage 3 combine, round half up, saturate.
  function automatic logic [DBITS:0] sat_f(input logic signed [SW-1:0] x);
    if (x > MaxC) begin
      return {1'b1, MaxC[DBITS-1:0]};
    end else if (x < MinC) begin
      return {1'b1, MinC[DBITS-1:0]};
    end
    return {1'b0, x[DBITS-1:0]};
  endfunction

  logic signed [SW-1:0] re_sum, im_sum, re_rnd, im_rnd;
  logic [DBITS:0]       re_sat, im_sat;

  always_comb begin
    re_sum = SW'(ac_q) - SW'(bd_q);
    im_sum = SW'(ad_q) + SW'(bc_q);
    re_rnd = (re_sum + RndC) >>> SH;
    im_rnd = (im_sum + RndC) >>> SH;
    re_sat = sat_f(re_rnd);
    im_sat = sat_f(im_rnd);
  end

  logic signed [DBITS-1:0] out_re_q, out_im_q;
  logic                    out_sof_q, out_eof_q, out_sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      v1_q        <= 1'b0;
      sof1_q      <= 1'b0;
      eof1_q      <= 1'b0;
      a1_q        <= '0;
      b1_q        <= '0;
      c1_q        <= '0;
      d1_q        <= '0;
      v2_q        <= 1'b0;
      sof2_q      <= 1'b0;
      eof2_q      <= 1'b0;
      ac_q        <= '0;
      bd_q        <= '0;
      ad_q        <= '0;
      bc_q        <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_sat_q   <= 1'b0;
    end else if (!stall) begin
      idx_q <= idx_d;

      v1_q <= accept;
      if (accept) begin
        a1_q   <= bus_io.in_re;
        b1_q   <= bus_io.in_im;
        c1_q   <= coef_re[sel];
        d1_q   <= coef_im[sel];
        sof1_q <= (sel == '0);
        eof1_q <= (sel == IW'(N - 1));
      end

      v2_q <= v1_q;
      if (v1_q) begin
        ac_q   <= ac_d;
        bd_q   <= bd_d;
        ad_q   <= ad_d;
        bc_q   <= bc_d;
        sof2_q <= sof1_q;
        eof2_q <= eof1_q;
      end

      out_valid_q <= v2_q;
      if (v2_q) begin
        out_re_q  <= re_sat[DBITS-1:0];
        out_im_q  <= im_sat[DBITS-1:0];
        out_sat_q <= re_sat[DBITS] | im_sat[DBITS];
        out_sof_q <= sof2_q;
        out_eof_q <= eof2_q;
      end
    end
  end

  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_re    = out_re_q;
  assign bus_io.out_im    = out_im_q;
  assign bus_io.out_sof   = out_sof_q;
  assign bus_io.out_eof   = out_eof_q;
  assign bus_io.out_sat   = out_sat_q;

endmodule

// File: tb/tb_twiddle_mult_stream0_1.sv
// Directed bench for twiddle_mult_stream0_1: reset, identity/rotation/half-scale/45-degree
// coefficients, saturation, index wrap, sof resync, mid-frame reset and backpressure.
module tb_twiddle_mult_stream0_1;
  localparam int NB = 11;
  localparam int NN = 32;
  localparam int DB = 11;

  logic clk = 1'b0;
  logic rst_n;
  logic [2*NB*NN-1:0] coeff;

  twiddle_mult_stream0_1_if #(.DBITS(DB)) bus ();

  twiddle_mult_stream0_1 #(.NBITS(NB), .N(NN), .DBITS(DB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coeff_data_i (coeff),
    .bus_io       (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cre [NN];
  int cim [NN];

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One isolated sample; checks it is absent after 2 cycles and present after 3.
  task automatic send_chk(input string tag, input logic sof, input int a, input int b,
                          input int er, input int ei, input int es, input int esof,
                          input int eeof);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_re    = DB'(a);
    bus.in_im    = DB'(b);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    @(negedge clk);
    chk({tag, ".lat"}, 32'(bus.out_valid), 0);
    @(negedge clk);
    chk({tag, ".valid"}, 32'(bus.out_valid), 1);
    chk({tag, ".re"}, 32'(bus.out_re), er);
    chk({tag, ".im"}, 32'(bus.out_im), ei);
    chk({tag, ".sat"}, 32'(bus.out_sat), es);
    chk({tag, ".sof"}, 32'(bus.out_sof), esof);
    chk({tag, ".eof"}, 32'(bus.out_eof), eeof);
  endtask

  // Back-to-back unchecked samples to advance the index, then idle.
  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_sof   = 1'b0;
      bus.in_re    = DB'(5);
      bus.in_im    = DB'(5);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [2*DB:0] ref_fn(input int a, input int b, input int k);
    int re, im;
    logic s;
    re = (a * cre[k] - b * cim[k] + 256) >>> 9;
    im = (a * cim[k] + b * cre[k] + 256) >>> 9;
    s = 1'b0;
    if (re > 1023) begin re = 1023; s = 1'b1; end
    if (re < -1024) begin re = -1024; s = 1'b1; end
    if (im > 1023) begin im = 1023; s = 1'b1; end
    if (im < -1024) begin im = -1024; s = 1'b1; end
    return {s, re[DB-1:0], im[DB-1:0]};
  endfunction

  function automatic int sa(input int k);
    return k * 30 - 480;
  endfunction

  function automatic int sb(input int k);
    return 400 - k * 25;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [25:0] held;
    logic held_v;
    logic acc;
    logic [2*DB:0] e;
    int sent, rcv;

    for (int k = 0; k < NN; k++) begin
      cre[k] = 512;
      cim[k] = 0;
    end
    cre[1] = 0;    cim[1] = 512;    // +j
    cre[2] = 256;  cim[2] = 0;      // 0.5
    cre[4] = 362;  cim[4] = 362;    // ~45 degrees
    cre[7] = -512; cim[7] = 0;      // -1
    cre[16] = 0;   cim[16] = -512;  // -j
    for (int k = 0; k < NN; k++) begin
      coeff[(NN-k)*2*NB-1 -: 2*NB] = {NB'(cre[k]), NB'(cim[k])};
    end

    // Reset with in_valid high.
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sof    = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.valid", 32'(bus.out_valid), 0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst.ready", 32'(bus.in_ready), 1);
    chk("rst.valid2", 32'(bus.out_valid), 0);
    chk("rst.re", 32'(bus.out_re), 0);
    chk("rst.im", 32'(bus.out_im), 0);
    chk("rst.sat", 32'(bus.out_sat), 0);

    // Frame A.
    send_chk("id0", 1'b1, 100, -50, 100, -50, 0, 1, 0);
    send_chk("plusj1", 1'b0, 300, 200, -200, 300, 0, 0, 0);
    send_chk("half2", 1'b0, 1, -1, 1, 0, 0, 0, 0);
    fill(1);
    send_chk("rot4", 1'b0, 100, 0, 71, 71, 0, 0, 0);
    fill(2);
    send_chk("neg7", 1'b0, -1024, 500, 1023, -500, 1, 0, 0);
    fill(8);
    send_chk("minusj16", 1'b0, 100, -50, -50, -100, 0, 0, 0);
    fill(14);
    send_chk("eof31", 1'b0, 20, -30, 20, -30, 0, 0, 1);

    // Frame B entered by wrap, no sof.
    send_chk("wrap0", 1'b0, 10, 20, 10, 20, 0, 1, 0);
    fill(15);
    send_chk("sat16", 1'b0, -1024, -1024, -1024, 1023, 1, 0, 0);

    // Resync: sof at index 7 uses coefficient 0, next sample uses coefficient 1.
    send_chk("rs.sof0", 1'b1, 5, 5, 5, 5, 0, 1, 0);
    fill(6);
    send_chk("rs.sof7", 1'b1, -300, 200, -300, 200, 0, 1, 0);
    send_chk("rs.next", 1'b0, 300, 200, -200, 300, 0, 0, 0);

    // Mid-frame asynchronous reset with a full pipeline.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_re    = DB'(7 + i);
      bus.in_im    = DB'(7 + i);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mrst.pre", 32'(bus.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst.valid", 32'(bus.out_valid), 0);
    chk("mrst.re", 32'(bus.out_re), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mrst.flush", 32'(bus.out_valid), 0);
    send_chk("mrst.idx0", 1'b0, 300, 200, 300, 200, 0, 1, 0);

    // Backpressure stream of one frame, out_ready pattern 1,0,0,1.
    sent = 0;
    rcv = 0;
    held = '0;
    held_v = 1'b0;
    for (int cyc = 0; cyc < 400 && rcv < NN; cyc++) begin
      @(negedge clk);
      if (held_v) begin
        chk("bp.hold", 32'({bus.out_valid, bus.out_sof, bus.out_eof, bus.out_sat,
                            bus.out_re, bus.out_im}), 32'(held));
        held_v = 1'b0;
      end
      bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      bus.in_valid  = (sent < NN);
      bus.in_sof    = (sent == 0);
      bus.in_re     = DB'(sa(sent));
      bus.in_im     = DB'(sb(sent));
      #1;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          e = ref_fn(sa(rcv), sb(rcv), rcv);
          chk("bp.data", 32'({bus.out_sat, bus.out_re, bus.out_im}), 32'(e));
          chk("bp.sof", 32'(bus.out_sof), 32'(rcv == 0));
          chk("bp.eof", 32'(bus.out_eof), 32'(rcv == NN - 1));
          rcv++;
        end else begin
          held = {bus.out_valid, bus.out_sof, bus.out_eof, bus.out_sat,
                  bus.out_re, bus.out_im};
          held_v = 1'b1;
        end
      end
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (acc) sent++;
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp.count", rcv, NN);
    chk("bp.sent", sent, NN);
    repeat (4) @(negedge clk);
    chk("bp.nodup", 32'(bus.out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
